segment_write_queue: RTL and testbench
======================================

// Module: segment_write_queue
// PURPOSE
//  Buffers segment-register writes (MOV Sreg, POP Sreg, far JMP/CALL/RET, LxS) from writeback and drains them into segment_register_file.
//  Drains at most one write per clock.
//  Drives the file's write_select/write_data/write_enable port.
//  Exports per-segment pending bits so decode/address-gen can stall on in-flight segment updates.
// PARAMETERS
//  DEPTH   4   queue entries; power of 2, >=2
//  PTR_W   2   log2(DEPTH)
//  DATA_W  16  segment selector width
// PORTS
//  clk               in   1       clock; all state updates on rising edge
//  reset             in   1       asynchronous, active-low; 0 clears all state immediately
//  in_valid          in   1       producer has a segment write
//  in_ready          out  1       queue can accept; = !full
//  in_seg            in   3       target: 0 ES,1 CS,2 SS,3 DS,4 FS,5 GS; 6/7 illegal
//  in_data           in   DATA_W  selector value
//  hold              in   1       1 = do not drain (exception/serialise)
//  flush             in   1       synchronous discard of all queued entries
//  seg_write_select  out  3       head entry segment code -> file write_select
//  seg_write_data    out  DATA_W  head entry data -> file write_data
//  seg_write_enable  out  1       = !empty & !hold & !flush -> file write_enable
//  pending           out  6       bit i = at least one queued entry targets segment code i
//  count             out  PTR_W+1 entries held, 0..DEPTH
//  empty, full       out  1       count==0 / count==DEPTH
//  err_invalid       out  1       registered 1-cycle pulse: illegal in_seg was accepted
// BEHAVIOUR
//  - Reset values (reset=0, async):
//    - count=0, empty=1, full=0, in_ready=1.
//    - seg_write_enable=0, pending=0, err_invalid=0.
//    - head/tail pointers=0, all pending counters=0.
//    - Select/data outputs are 0 (storage array need not be cleared).
//  - Enqueue:
//    - Fires when in_valid & in_ready & !flush & in_seg<=5.
//    - Writes storage[tail]; tail = tail+1 mod DEPTH.
//  - Illegal segment: in_valid & in_ready & in_seg>=6 is consumed but not stored; err_invalid=1 next cycle only.
//  - Dequeue:
//    - Fires when seg_write_enable=1. Head entry is combinational from storage[head].
//    - The file captures it on the same edge; head = head+1 mod DEPTH.
//  - Latency:
//    - Entry enqueued at edge N drives the write port in cycle N..N+1 (queue previously empty, hold=0).
//    - The file register updates at edge N+1.
//    - No bypass from in_* to the write port.
//  - Ordering: strict FIFO across all segments; writes to one segment land in program order.
//  - Full: in_ready=0 even if a dequeue fires the same cycle (no enqueue-on-full-with-dequeue).
//  - Simultaneous enqueue+dequeue (not full): count unchanged, both pointers advance.
//  - Pending tracking:
//    - One (PTR_W+1)-bit counter per segment; +1 on enqueue to that segment, -1 on dequeue from it.
//    - Both to the same segment in one cycle: counter unchanged. pending[i] = counter_i != 0.
//    - pending updates on the same edge as count.
//  - Flush:
//    - On the edge with flush=1: head=tail=0, count=0, all counters=0.
//    - Flush beats enqueue; the enqueue is dropped and in_ready is not stalled for it.
//    - seg_write_enable is 0 while flush=1.
//  - Hold: freezes draining only; enqueue continues until full.
//  - Reset mid-operation clears everything; queued writes are lost and the file is not written.
//  - Counters never wrap: count <= DEPTH by construction; underflow impossible since dequeue requires !empty.
// TESTING
//  1. Enqueue seg=3 data=16'h1234, hold=0.
//     -> next cycle seg_write_select=3, data=16'h1234, enable=1, pending=6'b001000.
//     -> after the following edge, ds_out=16'h1234, pending=0, empty=1.
//  2. hold=1, enqueue ES 0x0001, CS 0x0002, SS 0x0003, DS 0x0004.
//     -> full=1, in_ready=0, count=4, pending=6'b001111.
//     -> drop hold: four consecutive enable cycles in order ES,CS,SS,DS; then empty=1.
//  3. hold=1, enqueue CS 0x0010 then CS 0x0020.
//     -> pending[1]=1 until the second drain edge; final cs_out=16'h0020.
//  4. Hold count at 2; enqueue+dequeue every cycle for 10 cycles (pointers wrap twice).
//     -> count=2 throughout; data emerges in enqueue order.
//  5. Enqueue in_seg=7 -> no storage write, count unchanged, err_invalid=1 for exactly one cycle.
//  6. With count=3, assert flush with in_valid=1.
//     -> next cycle count=0, pending=0, enable=0.
//     -> assert reset=0 with count=2: outputs clear immediately, before any clock edge.

Source files
------------

// File: rtl/segment_write_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : segment_write_queue_if
//  Description : Producer-side handshake plus segment-register-file write
//                port for segment_write_queue.
//                  in_valid / in_ready / in_seg / in_data : writeback producer
//                  seg_write_select / _data / _enable     : register file port
//                master = producer/file side, slave = queue.
//  Revision    : 1.0  initial release
// ============================================================================
interface segment_write_queue_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_seg;
    logic [DATA_W-1:0] in_data;
    logic [2:0]        seg_write_select;
    logic [DATA_W-1:0] seg_write_data;
    logic              seg_write_enable;

    modport master (
        output in_valid, in_seg, in_data,
        input  in_ready, seg_write_select, seg_write_data, seg_write_enable
    );

    modport slave (
        input  in_valid, in_seg, in_data,
        output in_ready, seg_write_select, seg_write_data, seg_write_enable
    );
endinterface
`default_nettype wire

// File: rtl/segment_write_queue.sv
`default_nettype none
// ============================================================================
//  Module      : segment_write_queue
//  Description : FIFO of segment-register writes from writeback, drained at
//                most one per clock into the segment register file. Exports
//                per-segment pending bits for decode/address-gen stalls.
//  Ports       : clk         - clock, rising edge
//                reset       - asynchronous, active-low
//                bus         - producer handshake + file write port (slave)
//                hold        - 1 = do not drain
//                flush       - synchronous discard of all queued entries
//                pending     - bit i = a queued entry targets segment i
//                count       - entries held, 0..DEPTH
//                empty/full  - count==0 / count==DEPTH
//                err_invalid - 1-cycle pulse: illegal in_seg was consumed
//  Revision    : 1.0  initial release
// ============================================================================
module segment_write_queue #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int DATA_W = 16
) (
    input  wire logic                clk,
    input  wire logic                reset,
    segment_write_queue_if.slave     bus,
    input  wire logic                hold,
    input  wire logic                flush,
    output logic [5:0]               pending,
    output logic [PTR_W:0]           count,
    output logic                     empty,
    output logic                     full,
    output logic                     err_invalid
);

    localparam int          c_NSEG     = 6;
    localparam logic [2:0]  c_SEG_MAX  = 3'd5;

    // Storage is not reset; only pointers/count decide what is valid.
    logic [2:0]        r_mem_seg  [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [PTR_W:0]    r_count;
    logic [PTR_W:0]    r_pcnt [c_NSEG];
    logic              r_err;

    logic              w_empty;
    logic              w_full;
    logic              w_ready;
    logic              w_enq;
    logic              w_deq;
    logic              w_illegal;
    logic [2:0]        w_head_seg;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == (PTR_W+1)'(DEPTH));
    // A same-cycle dequeue does not free a slot for the producer.
    assign w_ready    = !w_full;
    assign w_enq      = bus.in_valid && w_ready && !flush && (bus.in_seg <= c_SEG_MAX);
    assign w_illegal  = bus.in_valid && w_ready && (bus.in_seg > c_SEG_MAX);
    assign w_deq      = !w_empty && !hold && !flush;
    assign w_head_seg = r_mem_seg[r_head];

    assign bus.in_ready         = w_ready;
    assign bus.seg_write_enable = w_deq;
    // Gated to zero when empty so the port reads 0 out of reset.
    assign bus.seg_write_select = w_empty ? 3'd0 : w_head_seg;
    assign bus.seg_write_data   = w_empty ? '0 : r_mem_data[r_head];

    assign count       = r_count;
    assign empty       = w_empty;
    assign full        = w_full;
    assign err_invalid = r_err;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem_seg[r_tail]  <= bus.in_seg;
            r_mem_data[r_tail] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < c_NSEG; i++) begin
                r_pcnt[i] <= '0;
            end
        end else begin
            r_err <= w_illegal;
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                for (int i = 0; i < c_NSEG; i++) begin
                    r_pcnt[i] <= '0;
                end
            end else begin
                if (w_enq) begin
                    r_tail <= r_tail + 1'b1;
                end
                if (w_deq) begin
                    r_head <= r_head + 1'b1;
                end
                r_count <= r_count + (PTR_W+1)'(w_enq) - (PTR_W+1)'(w_deq);
                // Enqueue and dequeue on the same segment cancel out.
                for (int i = 0; i < c_NSEG; i++) begin
                    r_pcnt[i] <= r_pcnt[i]
                               + (PTR_W+1)'(w_enq && (bus.in_seg == 3'(i)))
                               - (PTR_W+1)'(w_deq && (w_head_seg == 3'(i)));
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < c_NSEG; g++) begin : g_pend
            assign pending[g] = (r_pcnt[g] != '0);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_segment_write_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_segment_write_queue
//  Description : Directed self-checking bench for segment_write_queue, with
//                a six-entry segment register file model on the write port.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_segment_write_queue;

    logic        clk;
    logic        reset;
    logic        hold;
    logic        flush;
    logic [5:0]  pending;
    logic [2:0]  count;
    logic        empty;
    logic        full;
    logic        err_invalid;
    logic [15:0] seg_file [8];

    int errors = 0;
    int checks = 0;

    segment_write_queue_if #(.DATA_W(16)) bus ();

    segment_write_queue #(.DEPTH(4), .PTR_W(2), .DATA_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .hold        (hold),
        .flush       (flush),
        .pending     (pending),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .err_invalid (err_invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Segment register file model: captures the write port on the same edge.
    always @(posedge clk) begin
        if (bus.seg_write_enable) seg_file[bus.seg_write_select] <= bus.seg_write_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [15:0] d);
        bus.in_valid = v;
        bus.in_seg   = s;
        bus.in_data  = d;
    endtask

    task automatic test_reset();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%b full=%b exp 1 0", empty, full); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.seg_write_enable !== 1'b0 || pending !== 6'd0 || err_invalid !== 1'b0) begin
            errors++; $display("FAIL reset_outs got en=%b pend=%b err=%b exp 0 0 0", bus.seg_write_enable, pending, err_invalid); end
        checks++; if (bus.seg_write_select !== 3'd0 || bus.seg_write_data !== 16'h0) begin
            errors++; $display("FAIL reset_port got sel=%0d data=%h exp 0 0000", bus.seg_write_select, bus.seg_write_data); end
    endtask

    task automatic test_single();
        drive(1'b1, 3'd3, 16'h1234);
        tick();
        drive(1'b0, 3'd0, 16'h0);
        #1;
        checks++; if (bus.seg_write_select !== 3'd3 || bus.seg_write_data !== 16'h1234 || bus.seg_write_enable !== 1'b1) begin
            errors++; $display("FAIL single_port got sel=%0d data=%h en=%b exp 3 1234 1", bus.seg_write_select, bus.seg_write_data, bus.seg_write_enable); end
        checks++; if (pending !== 6'b001000) begin errors++; $display("FAIL single_pend got=%b exp=001000", pending); end
        tick();
        checks++; if (seg_file[3] !== 16'h1234) begin errors++; $display("FAIL single_ds got=%h exp=1234", seg_file[3]); end
        checks++; if (pending !== 6'd0 || empty !== 1'b1) begin errors++; $display("FAIL single_drained got pend=%b empty=%b exp 0 1", pending, empty); end
    endtask

    task automatic test_fill_drain();
        hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 3'(k), 16'(k + 1));
            tick();
        end
        drive(1'b0, 3'd0, 16'h0);
        #1;
        checks++; if (full !== 1'b1 || bus.in_ready !== 1'b0 || count !== 3'd4) begin
            errors++; $display("FAIL fill_full got full=%b rdy=%b cnt=%0d exp 1 0 4", full, bus.in_ready, count); end
        checks++; if (pending !== 6'b001111) begin errors++; $display("FAIL fill_pend got=%b exp=001111", pending); end
        hold = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus.seg_write_enable !== 1'b1 || bus.seg_write_select !== 3'(k) || bus.seg_write_data !== 16'(k + 1)) begin
                errors++; $display("FAIL drain_%0d got en=%b sel=%0d data=%h exp 1 %0d %h", k, bus.seg_write_enable, bus.seg_write_select, bus.seg_write_data, k, 16'(k + 1)); end
            tick();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
    endtask

    task automatic test_same_seg();
        hold = 1'b1;
        drive(1'b1, 3'd1, 16'h0010); tick();
        drive(1'b1, 3'd1, 16'h0020); tick();
        drive(1'b0, 3'd0, 16'h0);
        hold = 1'b0;
        #1;
        checks++; if (pending[1] !== 1'b1) begin errors++; $display("FAIL samseg_pend0 got=%b exp=1", pending[1]); end
        tick();
        checks++; if (pending[1] !== 1'b1 || seg_file[1] !== 16'h0010) begin
            errors++; $display("FAIL samseg_mid got pend=%b cs=%h exp 1 0010", pending[1], seg_file[1]); end
        tick();
        checks++; if (pending[1] !== 1'b0 || seg_file[1] !== 16'h0020) begin
            errors++; $display("FAIL samseg_end got pend=%b cs=%h exp 0 0020", pending[1], seg_file[1]); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] q[$];
        logic [15:0] d;
        hold = 1'b1;
        drive(1'b1, 3'd0, 16'h00A0); q.push_back(16'h00A0); tick();
        drive(1'b1, 3'd2, 16'h00A1); q.push_back(16'h00A1); tick();
        hold = 1'b0;
        for (int k = 0; k < 10; k++) begin
            d = 16'h00B0 + 16'(k);
            drive(1'b1, (k % 2 == 0) ? 3'd4 : 3'd5, d);
            #1;
            checks++; if (count !== 3'd2 || bus.seg_write_enable !== 1'b1 || bus.seg_write_data !== q[0]) begin
                errors++; $display("FAIL b2b_%0d got cnt=%0d en=%b data=%h exp 2 1 %h", k, count, bus.seg_write_enable, bus.seg_write_data, q[0]); end
            void'(q.pop_front());
            q.push_back(d);
            tick();
        end
        drive(1'b0, 3'd0, 16'h0);
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (bus.seg_write_data !== q[0]) begin
                errors++; $display("FAIL b2b_tail_%0d got=%h exp=%h", k, bus.seg_write_data, q[0]); end
            void'(q.pop_front());
            tick();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got=%b exp=1", empty); end
    endtask

    task automatic test_illegal();
        drive(1'b1, 3'd7, 16'hDEAD);
        tick();
        drive(1'b0, 3'd0, 16'h0);
        checks++; if (err_invalid !== 1'b1 || count !== 3'd0 || pending !== 6'd0) begin
            errors++; $display("FAIL illegal_pulse got err=%b cnt=%0d pend=%b exp 1 0 0", err_invalid, count, pending); end
        tick();
        checks++; if (err_invalid !== 1'b0) begin errors++; $display("FAIL illegal_clear got=%b exp=0", err_invalid); end
    endtask

    task automatic test_flush_reset();
        logic [15:0] es_before;
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 3'(k), 16'h0C00 + 16'(k));
            tick();
        end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre got=%0d exp=3", count); end
        hold  = 1'b0;
        flush = 1'b1;
        drive(1'b1, 3'd3, 16'h0C03);
        #1;
        checks++; if (bus.seg_write_enable !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_gate got en=%b rdy=%b exp 0 1", bus.seg_write_enable, bus.in_ready); end
        tick();
        flush = 1'b0;
        hold  = 1'b1;
        drive(1'b0, 3'd0, 16'h0);
        #1;
        checks++; if (count !== 3'd0 || pending !== 6'd0 || bus.seg_write_enable !== 1'b0) begin
            errors++; $display("FAIL flush_after got cnt=%0d pend=%b en=%b exp 0 0 0", count, pending, bus.seg_write_enable); end
        drive(1'b1, 3'd0, 16'h0E01); tick();
        drive(1'b1, 3'd3, 16'h0E02); tick();
        drive(1'b0, 3'd0, 16'h0);
        hold = 1'b0;
        es_before = seg_file[0];
        #2;
        reset = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || pending !== 6'd0 || empty !== 1'b1 || bus.seg_write_enable !== 1'b0) begin
            errors++; $display("FAIL async_rst got cnt=%0d pend=%b empty=%b en=%b exp 0 0 1 0", count, pending, empty, bus.seg_write_enable); end
        tick();
        checks++; if (seg_file[0] !== es_before) begin errors++; $display("FAIL rst_nowrite got=%h exp=%h", seg_file[0], es_before); end
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        drive(1'b0, 3'd0, 16'h0);
        for (int i = 0; i < 8; i++) seg_file[i] = 16'h0;
        tick();
        test_reset();
        reset = 1'b1;
        tick();
        test_single();
        test_fill_drain();
        test_same_seg();
        test_back_to_back();
        test_illegal();
        test_flush_reset();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
